// File: rtl/led_event_stretcher_pkg.sv
// Shared types and 84 MHz defaults for the LED event stretcher.
package led_event_stretcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } led_st_e;

    // 100 ms lit, 50 ms dark at 84 MHz
    localparam int DEF_ON_CYCLES  = 8_400_000;
    localparam int DEF_GAP_CYCLES = 4_200_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_event_stretcher_if.sv
// Event/LED bundle between core logic (master) and the stretcher (slave).
interface led_event_stretcher_if #(
    parameter int CH = 4
);
    logic [CH-1:0] event_i;
    logic          ovf_clr_i;
    logic [CH-1:0] led_o;
    logic [CH-1:0] busy_o;
    logic [CH-1:0] ovf_o;

    modport master (output event_i, ovf_clr_i, input led_o, busy_o, ovf_o);
    modport slave  (input event_i, ovf_clr_i, output led_o, busy_o, ovf_o);
endinterface

// File: rtl/led_event_stretcher_ch.sv
// One LED channel: IDLE/ON/GAP FSM, down-timer, pending-event queue count, sticky overflow.
module led_stretch_ch
    import led_event_stretcher_pkg::*;
#(
    parameter int ON_CYCLES  = DEF_ON_CYCLES,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int PEND_W     = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic event_i,
    input  logic ovf_clr_i,
    output logic lit_d_o,
    output logic busy_o,
    output logic ovf_o
);
    localparam int TW = $clog2(max_int(ON_CYCLES, GAP_CYCLES) + 1);
    localparam logic [TW-1:0] ON_LD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LD = TW'(GAP_CYCLES - 1);

    led_st_e           state_q, state_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic [PEND_W-1:0] pend_q, pend_d, pend_inc;
    logic              ovf_q, ovf_d, busy_q, busy_d, sat, ovf_set, tmr_zero;

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        pend_d   = pend_q;
        ovf_set  = 1'b0;
        tmr_zero = (tmr_q == '0);
        sat      = (pend_q == '1);
        pend_inc = sat ? pend_q : pend_q + PEND_W'(1);
        case (state_q)
            ST_IDLE: begin
                // a fresh event starts directly; otherwise drain the queue
                if (event_i || pend_q != '0) begin
                    state_d = ST_ON;
                    tmr_d   = ON_LD;
                    if (!event_i) pend_d = pend_q - PEND_W'(1);
                end
            end
            ST_ON: begin
                if (tmr_zero) begin
                    state_d = ST_GAP;
                    tmr_d   = GAP_LD;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
                if (event_i) pend_d = pend_inc;
                ovf_set = event_i & sat;
            end
            ST_GAP: begin
                if (tmr_zero) begin
                    if (pend_q != '0) begin
                        // consume one queued event; a same-cycle event replaces it
                        state_d = ST_ON;
                        tmr_d   = ON_LD;
                        if (!event_i) pend_d = pend_q - PEND_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                        pend_d  = event_i ? PEND_W'(1) : '0;
                    end
                end else begin
                    tmr_d = tmr_q - TW'(1);
                    if (event_i) pend_d = pend_inc;
                    ovf_set = event_i & sat;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ovf_d  = (ovf_q & ~ovf_clr_i) | ovf_set;
        busy_d = (state_d != ST_IDLE) || (pend_d != '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
        end
    end

    assign lit_d_o = (state_d == ST_ON);
    assign busy_o  = busy_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/led_event_stretcher.sv
// Multi-channel LED event stretcher; LED_ACTIVE_LOW_EN selects active-low led drive.
module led_event_stretcher
    import led_event_stretcher_pkg::*;
#(
    parameter int CH         = 4,
    parameter int ON_CYCLES  = DEF_ON_CYCLES,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int PEND_W     = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    led_event_stretcher_if.slave  bus
);
`ifdef LED_ACTIVE_LOW_EN
    localparam logic [CH-1:0] LED_OFF = '1;
`else
    localparam logic [CH-1:0] LED_OFF = '0;
`endif

    logic [CH-1:0] lit_d, busy_w, ovf_w, led_q;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        led_stretch_ch #(
            .ON_CYCLES (ON_CYCLES),
            .GAP_CYCLES(GAP_CYCLES),
            .PEND_W    (PEND_W)
        ) u_ch (
            .clock    (clock),
            .reset    (reset),
            .event_i  (bus.event_i[i]),
            .ovf_clr_i(bus.ovf_clr_i),
            .lit_d_o  (lit_d[i]),
            .busy_o   (busy_w[i]),
            .ovf_o    (ovf_w[i])
        );
    end

    // polarity is folded into the output flop so the pins never glitch
    always_ff @(posedge clock or posedge reset) begin
        if (reset) led_q <= LED_OFF;
        else       led_q <= lit_d ^ LED_OFF;
    end

    assign bus.led_o  = led_q;
    assign bus.busy_o = busy_w;
    assign bus.ovf_o  = ovf_w;

endmodule

// File: tb/tb_led_event_stretcher.sv
// Directed bench for led_event_stretcher with ON=4, GAP=2, PEND_W=2, CH=4.
module tb_led_event_stretcher;
    localparam int CH = 4;
`ifdef LED_ACTIVE_LOW_EN
    localparam logic [CH-1:0] OFF = 4'b1111;
`else
    localparam logic [CH-1:0] OFF = 4'b0000;
`endif

    logic clock = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;

    led_event_stretcher_if #(.CH(CH)) bus ();

    led_event_stretcher #(
        .CH(CH), .ON_CYCLES(4), .GAP_CYCLES(2), .PEND_W(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        total++; if (bus.led_o !== OFF) $display("FAIL reset_led got %b want %b", bus.led_o, OFF); else passed++;
        total++; if (bus.busy_o !== 4'b0) $display("FAIL reset_busy got %b want 0000", bus.busy_o); else passed++;
        total++; if (bus.ovf_o !== 4'b0) $display("FAIL reset_ovf got %b want 0000", bus.ovf_o); else passed++;
    endtask

    task automatic test_single();
        logic [CH-1:0] el, eb;
        bus.event_i = 4'b0001;
        for (int t = 1; t <= 8; t++) begin
            tick();
            bus.event_i = '0;
            el = (t <= 4) ? 4'b0001 : 4'b0000;
            eb = (t <= 6) ? 4'b0001 : 4'b0000;
            total++; if (bus.led_o !== (el ^ OFF)) $display("FAIL single_led t=%0d got %b want %b", t, bus.led_o, el ^ OFF); else passed++;
            total++; if (bus.busy_o !== eb) $display("FAIL single_busy t=%0d got %b want %b", t, bus.busy_o, eb); else passed++;
        end
    endtask

    task automatic test_queue();
        logic [CH-1:0] el, eb;
        for (int c = 0; c <= 20; c++) begin
            bus.event_i = (c == 0 || c == 2 || c == 3) ? 4'b0010 : 4'b0000;
            tick();
            el = ((c+1 >= 1 && c+1 <= 4) || (c+1 >= 7 && c+1 <= 10) || (c+1 >= 13 && c+1 <= 16)) ? 4'b0010 : 4'b0000;
            eb = (c+1 <= 18) ? 4'b0010 : 4'b0000;
            total++; if (bus.led_o !== (el ^ OFF)) $display("FAIL queue_led t=%0d got %b want %b", c+1, bus.led_o, el ^ OFF); else passed++;
            total++; if (bus.busy_o !== eb) $display("FAIL queue_busy t=%0d got %b want %b", c+1, bus.busy_o, eb); else passed++;
        end
        bus.event_i = '0;
        total++; if (bus.ovf_o !== 4'b0) $display("FAIL queue_ovf got %b want 0000", bus.ovf_o); else passed++;
    endtask

    task automatic test_saturate();
        logic [CH-1:0] el, eb, eo;
        for (int c = 0; c <= 26; c++) begin
            bus.event_i   = (c <= 5) ? 4'b0100 : 4'b0000;
            bus.ovf_clr_i = (c == 5);
            tick();
            el = ((c+1 >= 1 && c+1 <= 4) || (c+1 >= 7 && c+1 <= 10) ||
                  (c+1 >= 13 && c+1 <= 16) || (c+1 >= 19 && c+1 <= 22)) ? 4'b0100 : 4'b0000;
            eb = (c+1 <= 24) ? 4'b0100 : 4'b0000;
            eo = (c+1 >= 5) ? 4'b0100 : 4'b0000;
            total++; if (bus.led_o !== (el ^ OFF)) $display("FAIL sat_led t=%0d got %b want %b", c+1, bus.led_o, el ^ OFF); else passed++;
            total++; if (bus.busy_o !== eb) $display("FAIL sat_busy t=%0d got %b want %b", c+1, bus.busy_o, eb); else passed++;
            total++; if (bus.ovf_o !== eo) $display("FAIL sat_ovf t=%0d got %b want %b", c+1, bus.ovf_o, eo); else passed++;
        end
        bus.event_i   = '0;
        bus.ovf_clr_i = 1'b1;
        tick();
        bus.ovf_clr_i = 1'b0;
        total++; if (bus.ovf_o !== 4'b0) $display("FAIL ovf_clr got %b want 0000", bus.ovf_o); else passed++;
    endtask

    task automatic test_gap_exit_pend();
        logic [CH-1:0] el, eb;
        for (int c = 0; c <= 20; c++) begin
            bus.event_i = (c == 0 || c == 1 || c == 6) ? 4'b1000 : 4'b0000;
            tick();
            el = ((c+1 >= 1 && c+1 <= 4) || (c+1 >= 7 && c+1 <= 10) || (c+1 >= 13 && c+1 <= 16)) ? 4'b1000 : 4'b0000;
            eb = (c+1 <= 18) ? 4'b1000 : 4'b0000;
            total++; if (bus.led_o !== (el ^ OFF)) $display("FAIL gapx_led t=%0d got %b want %b", c+1, bus.led_o, el ^ OFF); else passed++;
            total++; if (bus.busy_o !== eb) $display("FAIL gapx_busy t=%0d got %b want %b", c+1, bus.busy_o, eb); else passed++;
        end
        bus.event_i = '0;
    endtask

    task automatic test_gap_exit_idle();
        logic [CH-1:0] el, eb;
        for (int c = 0; c <= 15; c++) begin
            bus.event_i = (c == 0 || c == 6) ? 4'b0001 : 4'b0000;
            tick();
            el = ((c+1 >= 1 && c+1 <= 4) || (c+1 >= 8 && c+1 <= 11)) ? 4'b0001 : 4'b0000;
            eb = (c+1 <= 13) ? 4'b0001 : 4'b0000;
            total++; if (bus.led_o !== (el ^ OFF)) $display("FAIL gapi_led t=%0d got %b want %b", c+1, bus.led_o, el ^ OFF); else passed++;
            total++; if (bus.busy_o !== eb) $display("FAIL gapi_busy t=%0d got %b want %b", c+1, bus.busy_o, eb); else passed++;
        end
        bus.event_i = '0;
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c <= 3; c++) begin
            bus.event_i = (c <= 2) ? 4'b0001 : 4'b0000;
            tick();
        end
        total++; if (bus.led_o !== (4'b0001 ^ OFF)) $display("FAIL rst_pre_led got %b want %b", bus.led_o, 4'b0001 ^ OFF); else passed++;
        #2 reset = 1'b1;
        #1;
        total++; if (bus.led_o !== OFF) $display("FAIL rst_async_led got %b want %b", bus.led_o, OFF); else passed++;
        total++; if (bus.busy_o !== 4'b0) $display("FAIL rst_async_busy got %b want 0000", bus.busy_o); else passed++;
        total++; if (bus.ovf_o !== 4'b0) $display("FAIL rst_async_ovf got %b want 0000", bus.ovf_o); else passed++;
        @(negedge clock);
        reset = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            total++; if (bus.led_o !== OFF) $display("FAIL rst_after_led t=%0d got %b want %b", t, bus.led_o, OFF); else passed++;
            total++; if (bus.busy_o !== 4'b0) $display("FAIL rst_after_busy t=%0d got %b want 0000", t, bus.busy_o); else passed++;
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.event_i   = '0;
        bus.ovf_clr_i = 1'b0;
        #2;
        test_reset();
        @(negedge clock);
        reset = 1'b0;
        tick();
        test_single();
        test_queue();
        test_saturate();
        test_gap_exit_pend();
        test_gap_exit_idle();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/led_event_stretcher.md
# led_event_stretcher

Multi-channel LED indicator driver that turns single-cycle event pulses from the fast clock domain into human-visible LED blinks. It is the output-side counterpart of the button debouncer/one-shot chain: that chain turns slow human input into clean single-cycle pulses, and this block turns single-cycle pulses back into slow human-visible output. Each channel queues events that arrive while a blink is in progress, so no event is silently lost up to the queue depth. It sits between core logic and the board `led` pins, clocked by the 84 MHz PSRAM clock.

## Interface
- `CH`, 4, number of independent LED channels.
- `ON_CYCLES`, 8_400_000, clocks an LED stays lit per event (100 ms at 84 MHz); must be at least 1.
- `GAP_CYCLES`, 4_200_000, forced dark clocks after each blink (50 ms); must be at least 1.
- `PEND_W`, 3, width of the per-channel pending-event counter (saturates at 2^PEND_W-1).
- `clock` input 1: single clock, every register rises on it.
- `reset` input 1: asynchronous, active-high; the only reset.
- `event` input CH: bit i high for one cycle means one event on channel i; a level held N cycles counts as N events.
- `ovf_clr` input 1: synchronous pulse that clears all `ovf` bits.
- `led` output CH: registered LED drive.
- `busy` output CH: channel i is in ON or GAP, or has pending > 0.
- `ovf` output CH: sticky flag; an event was dropped on channel i.

## Operation
- Per-channel FSM states: IDLE, ON, GAP. Per-channel down-timer of width $clog2(max(ON_CYCLES,GAP_CYCLES)+1). Per-channel `pend` counter of PEND_W bits.
- IDLE with event: move to ON, load timer with ON_CYCLES-1. The event is consumed directly and `pend` is unchanged.
- ON: `led` is lit. When the timer reaches 0, move to GAP and load timer with GAP_CYCLES-1.
- GAP: `led` is dark. When the timer reaches 0:
  - if `pend` > 0: decrement it, move to ON, load ON_CYCLES-1;
  - otherwise move to IDLE.
- Event while in ON or GAP: `pend` += 1, saturating at 2^PEND_W-1.
- Event while saturated: `pend` stays saturated and `ovf[i]` is set.
- Event in the same cycle as the GAP exit consume with `pend` > 0: net `pend` is unchanged and the channel still goes to ON.
- Same cycle, GAP exit with `pend` == 0 plus event: the event is counted into `pend` (becomes 1) and the channel moves to IDLE. The next cycle it goes IDLE→ON with `pend` decremented. IDLE also treats `pend` > 0 as a start request.
- `ovf_clr` and an overflowing event in the same cycle: set wins.
- Channels are fully independent; no arbitration.
- Reset mid-blink: state, timers, `pend` and `ovf` clear at once. Any queued events are discarded.

## Timing
- Reset values: state IDLE, `pend`=0, `ovf`=0, `busy`=0, `led`=inactive level (0 without the Configuration macro).
- Event sampled at edge n: `led` lit from edge n+1 for exactly ON_CYCLES clocks, then dark for exactly GAP_CYCLES clocks.
- Back-to-back queued blinks repeat with period ON_CYCLES+GAP_CYCLES.
- `busy` is registered and asserts at edge n+1 with `led`. It deasserts at the edge where the channel enters IDLE with `pend`=0.
- `ovf` is set at the edge following the dropped event.

## Configuration
- `LED_ACTIVE_LOW_EN` defined: `led` is driven inverted. It is lit=0 and resets to all-ones, matching the on-board Tang Nano LEDs.
- Not defined: lit=1, reset 0.
- `busy` and `ovf` are always active-high.

## Structure
- Shared package: FSM state enum (IDLE/ON/GAP, 2 bits) and the default ON/GAP cycle constants for 84 MHz.
- One sub-module `led_stretch_ch` implements one channel: FSM, timer, `pend`, `ovf`.
- The top generates CH instances and applies the active-low inversion at the output register.

## Test plan
Parameters for all runs: ON_CYCLES=4, GAP_CYCLES=2, PEND_W=2, CH=4.
- Single event on ch0 at cycle 10 -> `led[0]` lit cycles 11–14, dark 15–16; `busy[0]` high 11–16; other channels idle.
- Three events on ch1 at cycles 10, 12, 13 -> three blinks starting at 11, 17, 23; `ovf[1]`=0.
- Event held high 6 cycles on ch2 -> 1 immediate blink plus `pend` saturated at 3; `ovf[2]`=1 after the 5th event. Exactly 4 blinks total; `ovf_clr` then clears the flag.
- Event on ch3 exactly at the GAP-exit cycle with `pend`=1 -> the next blink starts with no extra gap and a further blink follows.
- Assert `reset` during ON with `pend`=2 -> `led` inactive and `busy`/`ovf` 0 immediately (asynchronous, no clock edge needed); no blinks after release.
- Repeat the single-event case with `LED_ACTIVE_LOW_EN` defined -> `led` resets to 4'b1111 and ch0 shows 0 for cycles 11–14.
